// File: rtl/ad9228_pkg.sv
// ============================================================================
// Module      : ad9228_pkg
// Description : Shared definitions for the AD9228-style serial LVDS
//               transmitter: default geometry, FSM state encoding and the
//               test-pattern selector codes/values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ad9228_pkg;

  // Default geometry: four lanes of 12-bit samples.
  localparam int c_DEFAULT_NUM_CHANNELS = 4;
  localparam int c_DEFAULT_DATA_WIDTH   = 12;

  // Alternating test-pattern words at the default 12-bit width. The top
  // builds the same bit pattern ({10} or {01} repeated) for any even width.
  localparam logic [11:0] c_PAT_AAA = 12'hAAA;
  localparam logic [11:0] c_PAT_555 = 12'h555;

  // testpat_sel encodings (only meaningful when the test-pattern build is on).
  localparam logic [1:0] c_TP_NORMAL = 2'b00;
  localparam logic [1:0] c_TP_ALT    = 2'b01;
  localparam logic [1:0] c_TP_RAMP   = 2'b10;
  localparam logic [1:0] c_TP_ONES   = 2'b11;

  // Transmitter state.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/ad9228_lane_serializer.sv
// ============================================================================
// Module      : ad9228_lane_serializer
// Description : One serial lane. Parallel load of a sample, MSB-first shift,
//               registered serial output.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   bit clock
//   rstn       in   synchronous active-low reset
//   load       in   capture load_data into the shift register
//   shift      in   emit the current MSB on dout and shift left
//   load_data  in   [DATA_WIDTH] sample to serialise
//   dout       out  registered serial bit (0 whenever shift is low)
// ============================================================================
`default_nettype none

module ad9228_lane_serializer
  import ad9228_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  dout
);

  logic [DATA_WIDTH-1:0] r_shreg;
  logic                  r_dout;

  // On a frame boundary load and shift coincide: the last bit of the old
  // frame leaves on dout while the new sample is captured, so frames run
  // back-to-back with no idle bit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_shreg <= '0;
      r_dout  <= 1'b0;
    end else begin
      r_dout <= shift ? r_shreg[DATA_WIDTH-1] : 1'b0;
      if (load) begin
        r_shreg <= load_data;
      end else if (shift) begin
        r_shreg <= {r_shreg[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

  assign dout = r_dout;

endmodule

`default_nettype wire

// File: rtl/ad9228_serial_tx.sv
// ============================================================================
// Module      : ad9228_serial_tx
// Description : Multi-lane serial sample transmitter in the AD9228 output
//               format: per-lane MSB-first data, frame clock high for the
//               first half of each frame, DCO gate, one-entry input holding
//               register with underflow detection (last word is repeated).
//               Optional test-pattern generator enabled by the macro
//               AD9228_TX_TESTPAT_EN (adds the testpat_sel input).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk              in   bit clock, one bit per lane per rising edge
//   rstn             in   synchronous active-low reset
//   tx_en            in   transmit enable (frames are never truncated)
//   testpat_sel      in   [2] 00 normal, 01 AAA/555, 10 ramp, 11 ones
//                         (only with AD9228_TX_TESTPAT_EN)
//   s_data           in   [NUM_CHANNELS*DATA_WIDTH] lane i at i*DATA_WIDTH
//   s_valid          in   s_data valid
//   s_ready          out  holding register can accept a word
//   dout             out  [NUM_CHANNELS] serial data, MSB first
//   fco              out  frame clock
//   dco_gate         out  high while frame bits are driven
//   underflow        out  one-cycle pulse when a frame repeats the last word
//   underflow_count  out  [16] saturating underflow counter
//   busy             out  transmitter in RUN state
// ============================================================================
`default_nettype none

module ad9228_serial_tx
  import ad9228_pkg::*;
#(
  parameter int NUM_CHANNELS = c_DEFAULT_NUM_CHANNELS,
  parameter int DATA_WIDTH   = c_DEFAULT_DATA_WIDTH
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               tx_en,
`ifdef AD9228_TX_TESTPAT_EN
  input  logic [1:0]                         testpat_sel,
`endif
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] s_data,
  input  logic                               s_valid,
  output logic                               s_ready,
  output logic [NUM_CHANNELS-1:0]            dout,
  output logic                               fco,
  output logic                               dco_gate,
  output logic                               underflow,
  output logic [15:0]                        underflow_count,
  output logic                               busy
);

  localparam int                 c_WORD_W   = NUM_CHANNELS * DATA_WIDTH;
  localparam int                 c_CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_HALF     = c_CNT_W'(DATA_WIDTH / 2);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  tx_state_t             r_state;
  logic [c_CNT_W-1:0]    r_bit_cnt;
  logic [c_WORD_W-1:0]   r_hold;
  logic                  r_hold_valid;
  logic [c_WORD_W-1:0]   r_last;
  logic                  r_fco;
  logic                  r_dco_gate;
  logic                  r_underflow;
  logic [15:0]           r_underflow_count;
  logic                  r_busy;

  logic                  w_normal;
  logic                  w_frame_end;
  logic                  w_start;
  logic                  w_reload;
  logic                  w_load;
  logic                  w_consume;
  logic                  w_starve;
  logic                  w_accept;
  logic                  w_shift;
  logic [c_WORD_W-1:0]   w_pat_word;
  logic [c_WORD_W-1:0]   w_load_word;

  // --------------------------------------------------------------------------
  // Test-pattern source
  // --------------------------------------------------------------------------
`ifdef AD9228_TX_TESTPAT_EN
  localparam logic [DATA_WIDTH-1:0] c_PAT_HI = {(DATA_WIDTH/2){2'b10}};
  localparam logic [DATA_WIDTH-1:0] c_PAT_LO = {(DATA_WIDTH/2){2'b01}};

  logic [DATA_WIDTH-1:0] r_ramp;
  logic                  r_alt_phase;
  logic [DATA_WIDTH-1:0] w_pat_lane;

  assign w_normal = (testpat_sel == c_TP_NORMAL);

  always_comb begin
    w_pat_lane = '1;
    case (testpat_sel)
      c_TP_ALT:  w_pat_lane = r_alt_phase ? c_PAT_LO : c_PAT_HI;
      c_TP_RAMP: w_pat_lane = r_ramp;
      default:   w_pat_lane = '1;
    endcase
  end

  // Pattern state advances once per frame actually loaded in that mode.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ramp      <= '0;
      r_alt_phase <= 1'b0;
    end else if (w_load) begin
      if (testpat_sel == c_TP_RAMP) begin
        r_ramp <= r_ramp + DATA_WIDTH'(1);
      end
      if (testpat_sel == c_TP_ALT) begin
        r_alt_phase <= ~r_alt_phase;
      end
    end
  end

  assign w_pat_word = {NUM_CHANNELS{w_pat_lane}};
`else
  assign w_normal   = 1'b1;
  assign w_pat_word = '0;
`endif

  // --------------------------------------------------------------------------
  // Frame control
  // --------------------------------------------------------------------------
  assign w_frame_end = (r_state == ST_RUN) && (r_bit_cnt == c_LAST_BIT);
  // A test pattern needs no input word, so it can start with hold empty.
  assign w_start     = (r_state == ST_IDLE) && tx_en && (r_hold_valid || !w_normal);
  assign w_reload    = w_frame_end && tx_en;
  assign w_load      = w_start || w_reload;
  assign w_consume   = w_load && w_normal && r_hold_valid;
  assign w_starve    = w_reload && w_normal && !r_hold_valid;
  assign w_shift     = (r_state == ST_RUN);

  // Ready also covers the consume cycle so a word can be accepted on the
  // same edge the previous one moves into the shift registers.
  assign s_ready     = !r_hold_valid || w_consume;
  assign w_accept    = s_valid && s_ready;

  assign w_load_word = !w_normal    ? w_pat_word :
                       r_hold_valid ? r_hold     : r_last;

  // --------------------------------------------------------------------------
  // Holding register and last-transmitted word
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_last       <= '0;
    end else begin
      if (w_accept) begin
        r_hold       <= s_data;
        r_hold_valid <= 1'b1;
      end else if (w_consume) begin
        r_hold_valid <= 1'b0;
      end
      if (w_consume) begin
        r_last <= r_hold;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State machine with registered status outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state           <= ST_IDLE;
      r_bit_cnt         <= '0;
      r_fco             <= 1'b0;
      r_dco_gate        <= 1'b0;
      r_busy            <= 1'b0;
      r_underflow       <= 1'b0;
      r_underflow_count <= '0;
    end else begin
      r_underflow <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_fco      <= 1'b0;
          r_dco_gate <= 1'b0;
          r_bit_cnt  <= '0;
          if (w_start) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          // Status tracks the bit the serializers emit on this same edge.
          r_fco      <= (r_bit_cnt < c_HALF);
          r_dco_gate <= 1'b1;
          if (r_bit_cnt == c_LAST_BIT) begin
            r_bit_cnt <= '0;
            if (!tx_en) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else if (w_starve) begin
              r_underflow <= 1'b1;
              if (r_underflow_count != 16'hFFFF) begin
                r_underflow_count <= r_underflow_count + 16'd1;
              end
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + c_CNT_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Lane serializers
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_lanes
    ad9228_lane_serializer #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
      .clk       (clk),
      .rstn      (rstn),
      .load      (w_load),
      .shift     (w_shift),
      .load_data (w_load_word[g*DATA_WIDTH +: DATA_WIDTH]),
      .dout      (dout[g])
    );
  end

  assign fco             = r_fco;
  assign dco_gate        = r_dco_gate;
  assign underflow       = r_underflow;
  assign underflow_count = r_underflow_count;
  assign busy            = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_ad9228_serial_tx.sv
// ============================================================================
// Module      : tb_ad9228_serial_tx
// Description : Self-checking bench for ad9228_serial_tx. Expected serial
//               streams come from a word-level model: a FIFO of accepted
//               words, one word per frame, repeating the previous word when
//               none is available. Test-pattern steps run when the bench is
//               built with AD9228_TX_TESTPAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ad9228_serial_tx;

  localparam int NC = 4;
  localparam int DW = 12;
  localparam int W  = NC * DW;

  logic          clk = 1'b0;
  logic          rstn;
  logic          tx_en;
  logic [W-1:0]  s_data;
  logic          s_valid;
  logic          s_ready;
  logic [NC-1:0] dout;
  logic          fco;
  logic          dco_gate;
  logic          underflow;
  logic [15:0]   underflow_count;
  logic          busy;
`ifdef AD9228_TX_TESTPAT_EN
  logic [1:0]    testpat_sel;
`endif

  ad9228_serial_tx #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .tx_en           (tx_en),
`ifdef AD9228_TX_TESTPAT_EN
    .testpat_sel     (testpat_sel),
`endif
    .s_data          (s_data),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .dout            (dout),
    .fco             (fco),
    .dco_gate        (dco_gate),
    .underflow       (underflow),
    .underflow_count (underflow_count),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Word-level reference model state.
  logic [W-1:0]  src_q[$];   // words waiting to be offered
  logic [W-1:0]  acc_q[$];   // accepted, not yet transmitted
  logic [W-1:0]  cur_w;      // word of the frame being sent
  logic [W-1:0]  last_w;     // last data word sent
  logic [DW-1:0] ramp_m;
  bit            alt_m;
  bit            uf_now;
  int            exp_ufc;
  int            tp_sel;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] repl(input logic [DW-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < NC; i++) r[i*DW +: DW] = x;
    return r;
  endfunction

  function automatic logic [W-1:0] rand_word();
    return {$urandom(), $urandom()};
  endfunction

  task automatic drive_src();
    s_valid = (src_q.size() != 0);
    if (s_valid) s_data = src_q[0];
  endtask

  // Called at the sample point; advances across one rising edge. is_load
  // tells the model a frame starts on this edge.
  task automatic tick(input bit is_load, input bit in_run);
    bit consumed;
    #3;
    consumed = is_load && (tp_sel == 0) && (acc_q.size() != 0);
    chk("s_ready", s_ready, (acc_q.size() == 0) || consumed);
    uf_now = 0;
    if (is_load) begin
      if (tp_sel == 1) begin
        cur_w = repl(alt_m ? 12'h555 : 12'hAAA);
        alt_m = !alt_m;
      end else if (tp_sel == 2) begin
        cur_w  = repl(ramp_m);
        ramp_m = ramp_m + 1'b1;
      end else if (tp_sel == 3) begin
        cur_w = '1;
      end else if (acc_q.size() != 0) begin
        cur_w  = acc_q.pop_front();
        last_w = cur_w;
      end else begin
        cur_w  = last_w;
        uf_now = in_run;
        if (uf_now && exp_ufc < 65535) exp_ufc++;
      end
    end
    if (s_valid && s_ready) begin
      acc_q.push_back(s_data);
      void'(src_q.pop_front());
    end
    @(posedge clk);
    #1;
    drive_src();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_dout"}, dout, '0);
    chk({tag, "_ctl"}, {fco, dco_gate, busy, underflow}, 4'b0000);
  endtask

  task automatic reset_dut(input string tag);
    rstn  = 1'b0;
    tx_en = 1'b0;
    src_q.delete();
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    acc_q.delete();
    last_w  = '0;
    exp_ufc = 0;
    ramp_m  = '0;
    alt_m   = 0;
    chk_idle(tag);
    chk({tag, "_ready"}, s_ready, 1'b1);
    chk({tag, "_ufc"}, underflow_count, 16'd0);
    rstn = 1'b1;
  endtask

  // Waits (bounded) for a word to reach the holding register, then starts.
  task automatic start_tx();
    int n = 0;
    tx_en = 1'b0;
    if (tp_sel == 0) begin
      while (acc_q.size() == 0 && n < 10) begin
        tick(0, 0);
        n++;
      end
      chk("hold_fill", acc_q.size() != 0, 1'b1);
    end
    tx_en = 1'b1;
    tick(1, 0);
    chk("start_dout", dout, '0);
    chk("start_ctl", {fco, dco_gate, busy, underflow}, 4'b0010);
  endtask

  // One frame. drop_k: bit index at which tx_en is lowered (-1 = keep);
  // inj_k: bit index at which a new random word is offered (-1 = none).
  task automatic do_frame(input int drop_k, input int inj_k);
    logic [W-1:0]  fw;
    logic [NC-1:0] ed;
    bit            keep;
    fw   = cur_w;
    keep = tx_en;
    for (int k = 0; k < DW; k++) begin
      if (k == drop_k) tx_en = 1'b0;
      if (k == inj_k) begin
        src_q.push_back(rand_word());
        drive_src();
      end
      keep = tx_en;
      tick((k == DW - 1) && keep, 1);
      for (int i = 0; i < NC; i++) ed[i] = fw[i*DW + DW - 1 - k];
      chk("dout", dout, ed);
      chk("ctl", {fco, dco_gate, busy, underflow},
          {k < DW/2, 1'b1, !((k == DW - 1) && !keep), (k == DW - 1) && uf_now});
    end
    if (!keep) begin
      tick(0, 0);
      chk_idle("post_frame");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w;
    int nw, nf, drop, inj;
    rstn = 1'b0; tx_en = 1'b0; s_valid = 1'b0; s_data = '0;
    tp_sel = 0; cur_w = '0;
`ifdef AD9228_TX_TESTPAT_EN
    testpat_sel = 2'b00;
`endif
    @(posedge clk);
    #1;
    reset_dut("reset");

    // Single word with 0xABC on lane 0, random on the others.
    w = rand_word();
    w[DW-1:0] = 12'hABC;
    src_q.push_back(w);
    drive_src();
    start_tx();
    chk("abc_word", cur_w[DW-1:0], 12'hABC);
    do_frame(DW - 1, -1);

    // Three words streamed with s_valid held: back-to-back, no underflow.
    for (int i = 0; i < 3; i++) src_q.push_back(rand_word());
    drive_src();
    start_tx();
    do_frame(-1, -1);
    do_frame(-1, -1);
    do_frame(DW - 1, -1);
    chk("stream_ufc", underflow_count, exp_ufc);

    // One word then starvation: three repeated frames.
    src_q.push_back(rand_word());
    drive_src();
    start_tx();
    do_frame(-1, -1);
    do_frame(-1, -1);
    do_frame(-1, -1);
    do_frame(DW - 1, -1);
    chk("repeat_ufc", underflow_count, exp_ufc);

    // tx_en dropped at bit 4: frame still completes.
    src_q.push_back(rand_word());
    drive_src();
    start_tx();
    do_frame(4, -1);

    // Randomised bursts with late arrivals and random stop points.
    for (int r = 0; r < 4; r++) begin
      nw = $urandom_range(1, 3);
      for (int i = 0; i < nw; i++) src_q.push_back(rand_word());
      drive_src();
      start_tx();
      nf = $urandom_range(2, 4);
      for (int f = 0; f < nf; f++) begin
        inj  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, DW - 1)) : -1;
        drop = (f == nf - 1) ? int'($urandom_range(0, DW - 1)) : -1;
        do_frame(drop, inj);
      end
      chk("rand_ufc", underflow_count, exp_ufc);
    end

    // Reset in the middle of a frame.
    src_q.push_back(rand_word());
    drive_src();
    start_tx();
    for (int k = 0; k < 6; k++) tick(0, 1);
    reset_dut("midreset");

`ifdef AD9228_TX_TESTPAT_EN
    // Ramp pattern with hold empty.
    tp_sel = 2;
    testpat_sel = 2'b10;
    start_tx();
    do_frame(-1, -1);
    do_frame(-1, -1);
    do_frame(DW - 1, -1);
    chk("ramp_ufc", underflow_count, 16'd0);
    // Alternating pattern.
    tp_sel = 1;
    testpat_sel = 2'b01;
    start_tx();
    do_frame(-1, -1);
    do_frame(DW - 1, -1);
    tp_sel = 0;
    testpat_sel = 2'b00;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
